// File: rtl/demux1x4_route_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer.
// Optional feature macro: DEMUX_COUNT_EN (per-channel transfer counters).
package demux1x4_route_pkg;

    localparam int unsigned NumCh    = 4;
    localparam int unsigned SelWidth = 2;
    localparam int unsigned DefWidth = 16;

    // Channel index names, matching the encoding of in_sel.
    typedef enum logic [SelWidth-1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } ch_e;

endpackage

// File: rtl/demux1x4_route_slot.sv
// One-entry output slot: data register plus valid flag, with an optional
// completed-transfer counter when DEMUX_COUNT_EN is defined.
module demux_slot
    import demux1x4_route_pkg::*;
#(
    parameter int unsigned width = DefWidth
`ifdef DEMUX_COUNT_EN
    ,
    parameter int unsigned cnt_width = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [width-1:0] data_i,
    output logic             valid_o,
    output logic [width-1:0] data_o
`ifdef DEMUX_COUNT_EN
    ,
    output logic [cnt_width-1:0] cnt_o
`endif
);

    logic             valid_q, valid_d;
    logic [width-1:0] data_q, data_d;

    // Next state: a load wins over a drain, so a same-cycle drain+load keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef DEMUX_COUNT_EN
    logic [cnt_width-1:0] cnt_q, cnt_d;

    // Count completed transfers; wraps naturally at 2^cnt_width.
    always_comb begin
        cnt_d = cnt_q;
        if (drain_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1x4_route.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshakes.
// Optional feature macro: DEMUX_COUNT_EN adds cnt0..cnt3 transfer counters.
module demux1x4_route
    import demux1x4_route_pkg::*;
#(
    parameter int unsigned width = DefWidth
`ifdef DEMUX_COUNT_EN
    ,
    parameter int unsigned cnt_width = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [width-1:0]    in_data,
    input  logic [SelWidth-1:0] in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [width-1:0]    out0_data,
    output logic                out0_valid,
    input  logic                out0_ready,
    output logic [width-1:0]    out1_data,
    output logic                out1_valid,
    input  logic                out1_ready,
    output logic [width-1:0]    out2_data,
    output logic                out2_valid,
    input  logic                out2_ready,
    output logic [width-1:0]    out3_data,
    output logic                out3_valid,
    input  logic                out3_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [cnt_width-1:0] cnt0,
    output logic [cnt_width-1:0] cnt1,
    output logic [cnt_width-1:0] cnt2,
    output logic [cnt_width-1:0] cnt3
`endif
);

    logic [NumCh-1:0] slot_valid;
    logic [NumCh-1:0] slot_ready;
    logic [NumCh-1:0] load;
    logic [NumCh-1:0] drain;
    logic [width-1:0] slot_data [NumCh];
    logic             accept;

    assign slot_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

    // Only the addressed channel can back-pressure; in_data never reaches in_ready.
    always_comb begin
        in_ready = 1'b1;
        unique case (ch_e'(in_sel))
            CH0: in_ready = ~slot_valid[0] | slot_ready[0];
            CH1: in_ready = ~slot_valid[1] | slot_ready[1];
            CH2: in_ready = ~slot_valid[2] | slot_ready[2];
            CH3: in_ready = ~slot_valid[3] | slot_ready[3];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Decode in_sel into a one-hot load strobe, gated by the accept handshake.
    always_comb begin
        load = '0;
        unique case (ch_e'(in_sel))
            CH0: load[0] = accept;
            CH1: load[1] = accept;
            CH2: load[2] = accept;
            CH3: load[3] = accept;
            default: load = '0;
        endcase
    end

    assign drain = slot_valid & slot_ready;

    for (genvar k = 0; k < NumCh; k++) begin : g_slot
`ifdef DEMUX_COUNT_EN
        logic [cnt_width-1:0] slot_cnt;
`endif
        demux_slot #(
            .width     (width)
`ifdef DEMUX_COUNT_EN
            ,
            .cnt_width (cnt_width)
`endif
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .drain_i (drain[k]),
            .data_i  (in_data),
            .valid_o (slot_valid[k]),
            .data_o  (slot_data[k])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt_o   (slot_cnt)
`endif
        );
    end

    assign out0_valid = slot_valid[0];
    assign out1_valid = slot_valid[1];
    assign out2_valid = slot_valid[2];
    assign out3_valid = slot_valid[3];
    assign out0_data  = slot_data[0];
    assign out1_data  = slot_data[1];
    assign out2_data  = slot_data[2];
    assign out3_data  = slot_data[3];

`ifdef DEMUX_COUNT_EN
    assign cnt0 = g_slot[0].slot_cnt;
    assign cnt1 = g_slot[1].slot_cnt;
    assign cnt2 = g_slot[2].slot_cnt;
    assign cnt3 = g_slot[3].slot_cnt;
`endif

endmodule

// File: tb/tb_demux1x4_route.sv
// Table-driven bench for demux1x4_route: directed per-cycle vectors, then
// asynchronous reset and (with DEMUX_COUNT_EN) counter wrap sequences.
module tb_demux1x4_route;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0_data, out1_data, out2_data, out3_data;
    logic         out0_valid, out1_valid, out2_valid, out3_valid;
    logic         out0_ready, out1_ready, out2_ready, out3_ready;
`ifdef DEMUX_COUNT_EN
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    demux1x4_route dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out3_data  (out3_data),
        .out3_valid (out3_valid),
        .out3_ready (out3_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3)
`endif
    );

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
        logic         valid;
        logic [3:0]   rdy;       // {out3..out0}_ready
        logic         exp_ready; // in_ready before the edge
        logic [3:0]   exp_vld;   // {out3..out0}_valid after the edge
        logic         chk_data;
        logic [1:0]   chk_ch;
        logic [W-1:0] exp_data;  // data of chk_ch after the edge
    } vec_t;

    vec_t vecs [12];

    function automatic logic [3:0] valids();
        return {out3_valid, out2_valid, out1_valid, out0_valid};
    endfunction

    function automatic logic [W-1:0] ch_data(input logic [1:0] ch);
        case (ch)
            2'd0:    return out0_data;
            2'd1:    return out1_data;
            2'd2:    return out2_data;
            default: return out3_data;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [W-1:0] data, input logic valid,
                         input logic [3:0] rdy);
        in_sel     = sel;
        in_data    = data;
        in_valid   = valid;
        {out3_ready, out2_ready, out1_ready, out0_ready} = rdy;
    endtask

    initial begin
        // sel, data, valid, rdy, exp_ready, exp_vld, chk_data, chk_ch, exp_data
        vecs[0]  = '{2'd2, 16'hA5A5, 1'b1, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hA5A5};
        vecs[1]  = '{2'd2, 16'h1234, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 16'hA5A5};
        vecs[2]  = '{2'd1, 16'hBEEF, 1'b1, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 16'hBEEF};
        vecs[3]  = '{2'd1, 16'h5555, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b1, 2'd1, 16'hBEEF};
        vecs[4]  = '{2'd3, 16'h0011, 1'b1, 4'b0010, 1'b1, 4'b1100, 1'b1, 2'd3, 16'h0011};
        vecs[5]  = '{2'd3, 16'h0022, 1'b1, 4'b1000, 1'b1, 4'b1100, 1'b1, 2'd3, 16'h0022};
        vecs[6]  = '{2'd0, 16'h0001, 1'b1, 4'b0001, 1'b1, 4'b1101, 1'b1, 2'd0, 16'h0001};
        vecs[7]  = '{2'd0, 16'h0002, 1'b1, 4'b0001, 1'b1, 4'b1101, 1'b1, 2'd0, 16'h0002};
        vecs[8]  = '{2'd0, 16'h0003, 1'b1, 4'b0001, 1'b1, 4'b1101, 1'b1, 2'd0, 16'h0003};
        vecs[9]  = '{2'd0, 16'h0004, 1'b1, 4'b0001, 1'b1, 4'b1101, 1'b1, 2'd0, 16'h0004};
        vecs[10] = '{2'd0, 16'hFFFF, 1'b0, 4'b0001, 1'b1, 4'b1100, 1'b1, 2'd2, 16'hA5A5};
        vecs[11] = '{2'd2, 16'hFFFF, 1'b0, 4'b1100, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};

        rst_n = 1'b0;
        drive(2'd0, '0, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(valids()), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(valids()), 32'(vecs[i].exp_vld));
            if (vecs[i].chk_data)
                check($sformatf("v%0d_data", i), 32'(ch_data(vecs[i].chk_ch)),
                      32'(vecs[i].exp_data));
        end

        // Fill channels 0 and 1, then reset between edges.
        @(negedge clk); drive(2'd0, 16'h1111, 1'b1, 4'b0000);
        @(negedge clk); drive(2'd1, 16'h2222, 1'b1, 4'b0000);
        @(negedge clk); drive(2'd0, '0, 1'b0, 4'b0000);
        #1;
        check("prefill_valid", 32'(valids()), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(valids()), 32'h0);
        check("async_reset_data", {out1_data, out0_data}, 32'h0);
        check("async_reset_data23", {out3_data, out2_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DEMUX_COUNT_EN
        // 257 words streamed through ch1 -> 257 drains, counter wraps to 1.
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            drive(2'd1, 16'(i), 1'b1, 4'b0010);
        end
        @(negedge clk);
        drive(2'd1, '0, 1'b0, 4'b0010);
        @(negedge clk);
        check("cnt1_wrap", 32'(cnt1), 32'd1);
        check("cnt_others", {8'h0, cnt0, cnt2, cnt3}, 32'h0);
        check("cnt_valid_after", 32'(valids()), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
